fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the async FIFO write port (Data_in/W_EN, write-clock domain) among NUM_REQ requesters.
- Grants one requester at a time, for a burst of up to MAX_BURST words.
- Gates every write with the FIFO FULL_flag.
- Sits in the W_CLK domain directly in front of the FIFO.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/fifo_wr_arbiter_rr_select.sv | 24 ++
 rtl/fifo_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;

  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_select.sv
// Rotate-priority encoder: first set request strictly after last_gnt, wrapping.
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_gnt,
  output logic [IDX_W-1:0]   sel,
  output logic               any_req
);

  always_comb begin
    int idx;
    idx     = 0;
    sel     = '0;
    any_req = |req;
    // Walk from farthest to nearest so the nearest candidate after last_gnt is written last.
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_gnt) + k) % NUM_REQ;
      if (req[idx]) sel = IDX_W'(idx);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ requesters.
// Optional WORD_CNT output enabled by defining FIFO_ARB_WORD_CNT_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_LAST,
  input  logic                          FULL_flag,
  output logic [NUM_REQ-1:0]            GNT,
  output logic [NUM_REQ-1:0]            ACK,
  output logic [DATA_WIDTH-1:0]         Data_in,
  output logic                          W_EN,
`ifdef FIFO_ARB_WORD_CNT_EN
  output logic                          BUSY,
  output logic [15:0]                   WORD_CNT
`else
  output logic                          BUSY
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BW    = burst_cnt_w(MAX_BURST);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   last_gnt_q, last_gnt_d;
  logic [BW-1:0]      burst_cnt_q, burst_cnt_d;
  logic               busy_q, busy_d;

  logic [IDX_W-1:0]   sel;
  logic               any_req;
  logic               accept;
  logic [BW-1:0]      burst_inc;

  rr_select #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_select (
    .req      (REQ),
    .last_gnt (last_gnt_q),
    .sel      (sel),
    .any_req  (any_req)
  );

  // While in XFER, last_gnt_q is the index of the current owner.
  assign accept    = (state_q == XFER) && REQ[last_gnt_q] && !FULL_flag;
  assign burst_inc = burst_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    burst_cnt_d = burst_cnt_q;
    busy_d      = busy_q;
    ACK         = '0;
    Data_in     = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = XFER;
          gnt_d        = '0;
          gnt_d[sel]   = 1'b1;
          last_gnt_d   = sel;
          burst_cnt_d  = '0;
          busy_d       = 1'b1;
        end
      end
      XFER: begin
        Data_in = REQ_DATA[int'(last_gnt_q)*DATA_WIDTH +: DATA_WIDTH];
        if (accept) begin
          ACK[last_gnt_q] = 1'b1;
          burst_cnt_d     = burst_inc;
        end
        // FULL stalls without exit; only LAST, burst limit or withdrawal end the grant.
        if ((accept && (REQ_LAST[last_gnt_q] || burst_inc == BW'(MAX_BURST))) ||
            !REQ[last_gnt_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      last_gnt_q  <= IDX_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign GNT  = gnt_q;
  assign BUSY = busy_q;
  assign W_EN = accept;

`ifdef FIFO_ARB_WORD_CNT_EN
  logic [15:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (accept && word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) word_cnt_q <= '0;
    else     word_cnt_q <= word_cnt_d;
  end

  assign WORD_CNT = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: driver predicts each cycle's outputs from a queue-free int model, monitor compares.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            RST;
  logic [N-1:0]    REQ;
  logic [N*DW-1:0] REQ_DATA;
  logic [N-1:0]    REQ_LAST;
  logic            FULL_flag;
  logic [N-1:0]    GNT, ACK;
  logic [DW-1:0]   Data_in;
  logic            W_EN, BUSY;
`ifdef FIFO_ARB_WORD_CNT_EN
  logic [15:0]     WORD_CNT;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .CLK(clk), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA), .REQ_LAST(REQ_LAST),
    .FULL_flag(FULL_flag), .GNT(GNT), .ACK(ACK), .Data_in(Data_in), .W_EN(W_EN),
`ifdef FIFO_ARB_WORD_CNT_EN
    .BUSY(BUSY), .WORD_CNT(WORD_CNT)
`else
    .BUSY(BUSY)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [N-1:0]  ack;
    logic          wen;
    logic          busy;
    logic [DW-1:0] data;
    logic [15:0]   wcnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference: owner = -1 when nobody holds the port.
  int owner  = -1;
  int last_g = N - 1;
  int words  = 0;
  int wcnt   = 0;

  task automatic drive(input logic [N-1:0] r, input logic [N*DW-1:0] d,
                       input logic [N-1:0] l, input logic f, input logic rs);
    exp_t e;
    logic acc;
    @(posedge clk);
    #1;
    REQ = r; REQ_DATA = d; REQ_LAST = l; FULL_flag = f; RST = rs;
    acc    = (owner >= 0) && r[owner] && !f;
    e.gnt  = (owner >= 0) ? N'(1 << owner) : '0;
    e.busy = (owner >= 0);
    e.wen  = acc;
    e.ack  = acc ? N'(1 << owner) : '0;
    e.data = (owner >= 0) ? d[owner*DW +: DW] : '0;
    e.wcnt = 16'(wcnt);
    sb.push_back(e);
    if (rs) begin
      owner = -1; last_g = N - 1; words = 0; wcnt = 0;
    end else begin
      if (acc && wcnt < 65535) wcnt++;
      if (owner < 0) begin
        for (int i = 1; i <= N; i++) begin
          if (r[(last_g + i) % N]) begin
            owner = (last_g + i) % N; last_g = owner; words = 0;
            break;
          end
        end
      end else if (acc) begin
        words++;
        if (l[owner] || words == MB) owner = -1;
      end else if (!r[owner]) begin
        owner = -1;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (GNT !== e.gnt || ACK !== e.ack || W_EN !== e.wen || BUSY !== e.busy ||
          Data_in !== e.data
`ifdef FIFO_ARB_WORD_CNT_EN
          || WORD_CNT !== e.wcnt
`endif
         ) begin
        fails++;
        $display("FAIL cycle%0d got gnt=%b ack=%b wen=%b busy=%b data=%h want gnt=%b ack=%b wen=%b busy=%b data=%h wcnt=%0d",
                 cyc, GNT, ACK, W_EN, BUSY, Data_in, e.gnt, e.ack, e.wen, e.busy, e.data, e.wcnt);
      end
    end
  end

  function automatic logic [N*DW-1:0] rep(input logic [DW-1:0] b);
    return {N{b}};
  endfunction

  initial begin
    RST = 1'b1; REQ = '1; REQ_DATA = '0; REQ_LAST = '0; FULL_flag = 1'b0;
    @(posedge clk);
    // Reset hold with all requests, then requester 0 wins first.
    drive(4'b1111, rep(8'h11), 4'b1111, 1'b0, 1'b1);
    drive(4'b1111, rep(8'h11), 4'b1111, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(4'b1111, rep(8'h12), 4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) drive(4'b0000, '0, '0, 1'b0, 1'b0);
    // Single requester packet A0..A2.
    drive(4'b0100, rep(8'hA0), 4'b0000, 1'b0, 1'b0);
    drive(4'b0100, rep(8'hA0), 4'b0000, 1'b0, 1'b0);
    drive(4'b0100, rep(8'hA1), 4'b0000, 1'b0, 1'b0);
    drive(4'b0100, rep(8'hA2), 4'b0100, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) drive(4'b0000, '0, '0, 1'b0, 1'b0);
    // Burst limit on requester 1.
    for (int i = 0; i < 12; i++) drive(4'b0010, rep(8'(8'hB0 + i)), 4'b0000, 1'b0, 1'b0);
    drive(4'b0000, '0, '0, 1'b0, 1'b0);
    // Round robin across 0,1,3 with single-word packets.
    for (int i = 0; i < 12; i++) drive(4'b1011, rep(8'(8'hC0 + i)), 4'b1111, 1'b0, 1'b0);
    drive(4'b0000, '0, '0, 1'b0, 1'b0);
    // FULL stall mid-burst.
    for (int i = 0; i < 3; i++) drive(4'b0001, rep(8'(8'hD0 + i)), 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(4'b0001, rep(8'hDF), 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(4'b0001, rep(8'(8'hD3 + i)), 4'b0000, 1'b0, 1'b0);
    drive(4'b0000, '0, '0, 1'b0, 1'b0);
    // Reset after two words of a burst; the reset-cycle word is still written.
    for (int i = 0; i < 3; i++) drive(4'b0001, rep(8'(8'hE0 + i)), 4'b0000, 1'b0, 1'b0);
    drive(4'b0001, rep(8'hE3), 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) drive(4'b0000, '0, '0, 1'b0, 1'b0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(N'($urandom), {$urandom}, N'($urandom & $urandom),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 99) == 0));
    end
    for (int i = 0; i < 3; i++) drive(4'b0000, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
